// File: rtl/vx_fpu_rsp_arb.sv
// Round-robin merge of FPU sub-core result streams into one registered writeback port.
// Optional FPU_RSP_ARB_PERF_EN adds stall and conflict cycle counters.
module vx_fpu_rsp_arb #(
  parameter int NUM_REQS = 10,
  parameter int DATAW    = 128,
  parameter int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [SELW-1:0]           sel_out,
  input  logic                      ready_out
`ifdef FPU_RSP_ARB_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_conflict_cycles
`endif
);

  localparam logic [SELW:0]   NUM_REQS_W = (SELW+1)'(NUM_REQS);
  localparam logic [SELW-1:0] LAST_IDX   = SELW'(NUM_REQS - 1);

  logic [SELW-1:0]       r_rr_last;
  logic                  r_out_valid;
  logic [DATAW-1:0]      r_out_data;
  logic [SELW-1:0]       r_out_sel;

  logic                  w_stage_ready;
  logic [SELW-1:0]       w_start;
  logic [NUM_REQS-1:0]   w_grant;
  logic [SELW-1:0]       w_grant_idx;
  logic                  w_fire;
  logic [DATAW-1:0]      w_masked [NUM_REQS];
  logic [DATAW-1:0]      w_grant_data;

  assign w_stage_ready = !r_out_valid || ready_out;
  assign w_start       = (r_rr_last == LAST_IDX) ? '0 : r_rr_last + 1'b1;

  // Scan upward from the entry after the last winner, wrapping once around.
  always_comb begin
    logic [SELW:0] w_idx_ext;
    logic          w_found;
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_idx_ext   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_idx_ext = {1'b0, w_start} + (SELW+1)'(k);
      if (w_idx_ext >= NUM_REQS_W) begin
        w_idx_ext = w_idx_ext - NUM_REQS_W;
      end
      if (!w_found && valid_in[w_idx_ext[SELW-1:0]]) begin
        w_found                           = 1'b1;
        w_grant[w_idx_ext[SELW-1:0]]      = 1'b1;
        w_grant_idx                       = w_idx_ext[SELW-1:0];
      end
    end
  end

  assign w_fire   = (|w_grant) && w_stage_ready && !reset;
  assign ready_in = w_grant & {NUM_REQS{w_stage_ready && !reset}};

  // Grant is one-hot, so an AND-OR tree selects the winning payload.
  generate
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_mask
      assign w_masked[gi] = data_in[gi*DATAW +: DATAW] & {DATAW{w_grant[gi]}};
    end
  endgenerate

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_grant_data = w_grant_data | w_masked[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_last   <= LAST_IDX;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_fire) begin
      r_rr_last   <= w_grant_idx;
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_sel   <= w_grant_idx;
    end else if (ready_out) begin
      r_out_valid <= 1'b0;
    end
  end

  assign valid_out = r_out_valid;
  assign data_out  = r_out_data;
  assign sel_out   = r_out_sel;

`ifdef FPU_RSP_ARB_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_conflict_cnt;
  logic        w_conflict;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_conflict = (valid_in & (valid_in - 1'b1)) != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (r_out_valid && !ready_out) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_conflict) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_cycles    = r_stall_cnt;
  assign perf_conflict_cycles = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_vx_fpu_rsp_arb.sv
// Scoreboard bench for vx_fpu_rsp_arb: directed scenarios then randomized traffic.
module tb_vx_fpu_rsp_arb;
  localparam int N  = 10;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    valid_in = '0;
  logic [N*DW-1:0] data_in = '0;
  logic [N-1:0]    ready_in;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic [3:0]      sel_out;
  logic            ready_out = 1'b0;
`ifdef FPU_RSP_ARB_PERF_EN
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_conflict_cycles;
`endif

  vx_fpu_rsp_arb #(.NUM_REQS(N), .DATAW(DW)) dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .data_in(data_in),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .data_out(data_out),
    .sel_out(sel_out),
    .ready_out(ready_out)
`ifdef FPU_RSP_ARB_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_conflict_cycles(perf_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            sel;
  } exp_t;

  int            n_err = 0;
  int            n_chk = 0;
  exp_t          sb[$];
  logic [DW-1:0] dat [N];
  int            m_rr = N - 1;
  bit            m_valid = 1'b0;
  logic [N-1:0]  last_exp_ready = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; the reference model picks the winner by searching the
  // circular order after the last winner, and queues what should come out.
  task automatic step(input logic [N-1:0] vin, input logic rdy, input logic rst);
    int g;
    bit stage;
    @(negedge clk);
    reset     = rst;
    valid_in  = vin;
    ready_out = rdy;
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = dat[i];
    #1;
    chk("valid_out", {127'b0, valid_out}, {127'b0, m_valid});
    stage = !m_valid || rdy;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + 1 + k) % N;
      if (g < 0 && vin[i]) g = i;
    end
    last_exp_ready = (!rst && stage && g >= 0) ? (N'(1) << g) : '0;
    chk("ready_in", {118'b0, ready_in}, {118'b0, last_exp_ready});
    if (rst) begin
      m_valid = 1'b0;
      m_rr    = N - 1;
      sb.delete();
    end else if (stage && g >= 0) begin
      sb.push_back('{dat[g], g});
      m_rr    = g;
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: every consumed output must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && valid_out && ready_out) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL monitor: output sel=%0d data=%0h but none expected", sel_out, data_out);
        end else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.data);
          chk("sel_out", {124'b0, sel_out}, DW'(e.sel));
          $display("xfer sel=%0d data=%0h", sel_out, data_out);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] vin;
    for (int i = 0; i < N; i++) dat[i] = DW'(32'h1000 + i);

    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);

    repeat (5) begin
      step('0, 1'b1, 1'b0);
      chk("idle_data", data_out, '0);
      chk("idle_sel", {124'b0, sel_out}, '0);
    end

    dat[3] = DW'(8'hA5);
    step(10'h008, 1'b1, 1'b0);
    chk("single_ready", {118'b0, ready_in}, 128'h008);
    step('0, 1'b1, 1'b0);
    chk("single_valid", {127'b0, valid_out}, 128'h1);
    chk("single_sel", {124'b0, sel_out}, 128'd3);
    chk("single_data", data_out, 128'hA5);

    step('0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      step('1, 1'b1, 1'b0);
      chk("rr_ready", {118'b0, ready_in}, DW'(10'(1) << (k % 10)));
      if (k > 0) chk("rr_valid", {127'b0, valid_out}, 128'h1);
    end
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);

    step(10'h004, 1'b1, 1'b0);
    repeat (4) begin
      step(10'h020, 1'b0, 1'b0);
      chk("bp_ready", {118'b0, ready_in}, '0);
      chk("bp_sel", {124'b0, sel_out}, 128'd2);
      chk("bp_data", data_out, dat[2]);
    end
    step(10'h020, 1'b1, 1'b0);
    chk("bp_release", {118'b0, ready_in}, 128'h020);
    step('0, 1'b1, 1'b0);
    chk("bp_sel5", {124'b0, sel_out}, 128'd5);

    step(10'h010, 1'b1, 1'b0);
    step('1, 1'b0, 1'b1);
    step('1, 1'b1, 1'b0);
    chk("rst_valid", {127'b0, valid_out}, '0);
    chk("rst_grant", {118'b0, ready_in}, 128'h001);
    step('0, 1'b1, 1'b0);

    vin = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vin[i] && $urandom_range(0, 2) == 0) begin
          vin[i] = 1'b1;
          dat[i] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      step(vin, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
      vin = vin & ~last_exp_ready;
    end
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("sb_empty", DW'(sb.size()), '0);

`ifdef FPU_RSP_ARB_PERF_EN
    step('0, 1'b0, 1'b1);
    step(10'h001, 1'b1, 1'b0);
    repeat (3) step('0, 1'b0, 1'b0);
    step(10'h011, 1'b1, 1'b0);
    step(10'h011, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    chk("perf_stall", {96'b0, perf_stall_cycles}, 128'd3);
    chk("perf_conflict", {96'b0, perf_conflict_cycles}, 128'd2);
    step('0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
